// File: rtl/lsu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_pkg : access-size encodings and FSM state type for lsu_ctrl  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package lsu_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_extend.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_extend : selects the read lane by size and sign/zero-extends  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rdata32,
  input  logic [15:0] rdata16,
  input  logic [7:0]  rdata8,
  output logic [31:0] result
);

  always_comb begin
    result = rdata32;
    case (size)
      SZ_HALF: result = {{16{~is_unsigned & rdata16[15]}}, rdata16};
      SZ_BYTE: result = {{24{~is_unsigned & rdata8[7]}}, rdata8};
      default: result = rdata32;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_ctrl : single-outstanding load/store controller (IDLE/ACCESS/ |
// | RESP). Macro LSU_MISALIGN_TRAP_EN traps misaligned word accesses. |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dm_ena,
  output logic        dm_wr,
  output logic [1:0]  dm_w,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata32,
  output logic [15:0] dm_wdata16,
  output logic [7:0]  dm_wdata8,
  input  logic [31:0] dm_rdata32,
  input  logic [15:0] dm_rdata16,
  input  logic [7:0]  dm_rdata8
);

  localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

  lsu_state_t  state, state_nxt;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        illegal;
  logic [31:0] addr_eff;
  logic [31:0] ext_data;

  // Legality is decided from the live request so errors skip ACCESS entirely.
  always_comb begin
    illegal  = 1'b0;
    addr_eff = req_addr;
    if (req_size == SZ_ILL) illegal = 1'b1;
    if ((req_size == SZ_HALF) && req_addr[0]) illegal = 1'b1;
    if (req_size == SZ_WORD) begin
`ifdef LSU_MISALIGN_TRAP_EN
      if (req_addr[1:0] != 2'b00) illegal = 1'b1;
`else
      addr_eff = {req_addr[31:2], 2'b00};
`endif
    end
    if ({2'b00, req_addr[31:2]} >= DEPTH_LIMIT) illegal = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dm_ena     = 1'b0;
    dm_wr      = 1'b0;
    dm_w       = 2'b00;
    dm_addr    = 32'h0;
    dm_wdata32 = 32'h0;
    dm_wdata16 = 16'h0;
    dm_wdata8  = 8'h0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = illegal ? RESP : ACCESS;
      end
      ACCESS: begin
        dm_ena     = 1'b1;
        dm_wr      = we_q;
        dm_w       = size_q;
        dm_addr    = addr_q;
        dm_wdata32 = wdata_q;
        dm_wdata16 = wdata_q[15:0];
        dm_wdata8  = wdata_q[7:0];
        state_nxt  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  lsu_extend u_extend (
    .size        (size_q),
    .is_unsigned (uns_q),
    .rdata32     (dm_rdata32),
    .rdata16     (dm_rdata16),
    .rdata8      (dm_rdata8),
    .result      (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else if ((state == IDLE) && req_valid) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      err_q   <= illegal;
      size_q  <= req_size;
      addr_q  <= addr_eff;
      wdata_q <= req_wdata;
      rdata_q <= 32'h0;
    end else if (state == ACCESS) begin
      rdata_q <= we_q ? 32'h0 : ext_data;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_lsu_ctrl : directed vector bench for lsu_ctrl with byte memory |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err, dm_ena, dm_wr;
  logic [1:0]  dm_w;
  logic [31:0] resp_rdata, dm_addr, dm_wdata32, dm_rdata32;
  logic [15:0] dm_wdata16, dm_rdata16;
  logic [7:0]  dm_wdata8, dm_rdata8;
  logic        mem_init = 1'b1;

  int checks = 0;
  int failures = 0;

  lsu_ctrl #(.DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_ena(dm_ena), .dm_wr(dm_wr), .dm_w(dm_w), .dm_addr(dm_addr),
    .dm_wdata32(dm_wdata32), .dm_wdata16(dm_wdata16), .dm_wdata8(dm_wdata8),
    .dm_rdata32(dm_rdata32), .dm_rdata16(dm_rdata16), .dm_rdata8(dm_rdata8)
  );

  always #5 clk = ~clk;

  // Little-endian 4 KiB byte memory with lane-aligned combinational reads.
  logic [7:0]  mem [0:4095];
  logic [11:0] ma;
  assign ma = dm_addr[11:0];

  always_comb begin
    dm_rdata32 = {mem[{ma[11:2], 2'd3}], mem[{ma[11:2], 2'd2}],
                  mem[{ma[11:2], 2'd1}], mem[{ma[11:2], 2'd0}]};
    dm_rdata16 = {mem[{ma[11:1], 1'b1}], mem[{ma[11:1], 1'b0}]};
    dm_rdata8  = mem[ma];
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (dm_ena && dm_wr) begin
      case (dm_w)
        2'b00: begin
          mem[{ma[11:2], 2'd0}] <= dm_wdata32[7:0];
          mem[{ma[11:2], 2'd1}] <= dm_wdata32[15:8];
          mem[{ma[11:2], 2'd2}] <= dm_wdata32[23:16];
          mem[{ma[11:2], 2'd3}] <= dm_wdata32[31:24];
        end
        2'b01: begin
          mem[{ma[11:1], 1'b0}] <= dm_wdata16[7:0];
          mem[{ma[11:1], 1'b1}] <= dm_wdata16[15:8];
        end
        2'b10: mem[ma] <= dm_wdata8;
        default: ;
      endcase
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] dmaddr;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) chk({nm, "_ready_timeout"}, 32'(req_ready), 32'h1);
  endtask

  task automatic issue(input vec_t v);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    string nm;
    nm = $sformatf("v%0d", id);
    wait_ready(nm);
    issue(v);
    @(negedge clk);
    if (v.err) begin
      chk({nm, "_err_valid"}, 32'(resp_valid), 32'h1);
      chk({nm, "_err_flag"}, 32'(resp_err), 32'h1);
      chk({nm, "_err_dm_ena"}, 32'(dm_ena), 32'h0);
      chk({nm, "_err_rdata"}, resp_rdata, 32'h0);
    end else begin
      chk({nm, "_dm_ena"}, 32'(dm_ena), 32'h1);
      chk({nm, "_dm_wr"}, 32'(dm_wr), 32'(v.we));
      chk({nm, "_dm_w"}, 32'(dm_w), 32'(v.size));
      chk({nm, "_dm_addr"}, dm_addr, v.dmaddr);
      chk({nm, "_early_valid"}, 32'(resp_valid), 32'h0);
      if (v.we) begin
        chk({nm, "_wdata32"}, dm_wdata32, v.wdata);
        chk({nm, "_wdata16"}, 32'(dm_wdata16), {16'h0, v.wdata[15:0]});
        chk({nm, "_wdata8"}, 32'(dm_wdata8), {24'h0, v.wdata[7:0]});
      end
      @(negedge clk);
      chk({nm, "_valid"}, 32'(resp_valid), 32'h1);
      chk({nm, "_err0"}, 32'(resp_err), 32'h0);
      chk({nm, "_rdata"}, resp_rdata, v.rdata);
      chk({nm, "_dm_idle"}, 32'(dm_ena), 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    vecs[0]  = '{1'b1, 2'b00, 1'b0, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0,        32'h10};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF, 32'h10};
    vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h21,       32'hFFFFFF80, 1'b0, 32'h0,        32'h21};
    vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h21,       32'h0,        1'b0, 32'hFFFFFF80, 32'h21};
    vecs[4]  = '{1'b0, 2'b10, 1'b1, 32'h21,       32'h0,        1'b0, 32'h00000080, 32'h21};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h13,       32'h0,        1'b1, 32'h0,        32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h12,       32'h0,        1'b1, 32'h0,        32'h0};
`else
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h12,       32'h0,        1'b0, 32'hDEADBEEF, 32'h10};
`endif
    vecs[7]  = '{1'b0, 2'b00, 1'b0, 32'h1000,     32'h0,        1'b1, 32'h0,        32'h0};
    vecs[8]  = '{1'b0, 2'b11, 1'b0, 32'h10,       32'h0,        1'b1, 32'h0,        32'h0};
    vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h22,       32'hA5A51234, 1'b0, 32'h0,        32'h22};
    vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h22,       32'h0,        1'b0, 32'h00001234, 32'h22};
    vecs[11] = '{1'b0, 2'b01, 1'b0, 32'h20,       32'h0,        1'b0, 32'hFFFF8000, 32'h20};
    vecs[12] = '{1'b0, 2'b01, 1'b1, 32'h20,       32'h0,        1'b0, 32'h00008000, 32'h20};
    vecs[13] = '{1'b0, 2'b00, 1'b0, 32'h20,       32'h0,        1'b0, 32'h12348000, 32'h20};
    vecs[14] = '{1'b1, 2'b00, 1'b0, 32'hFFC,      32'h0BADF00D, 1'b0, 32'h0,        32'hFFC};
    vecs[15] = '{1'b0, 2'b00, 1'b0, 32'hFFC,      32'h0,        1'b0, 32'h0BADF00D, 32'hFFC};
    vecs[16] = '{1'b0, 2'b10, 1'b0, 32'hFFD,      32'h0,        1'b0, 32'hFFFFFFF0, 32'hFFD};
    vecs[17] = '{1'b1, 2'b10, 1'b0, 32'h1000,     32'h11,       1'b1, 32'h0,        32'h0};
    vecs[18] = '{1'b0, 2'b00, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0,        32'h0};

    // Reset must take effect before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_dm_ena", 32'(dm_ena), 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);

    // Back-pressure: response must hold while resp_ready stays low.
    wait_ready("hold");
    v = vecs[1];
    issue(v);
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d_valid", k), 32'(resp_valid), 32'h1);
      chk($sformatf("hold%0d_rdata", k), resp_rdata, 32'hDEADBEEF);
      chk($sformatf("hold%0d_req_ready", k), 32'(req_ready), 32'h0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("hold_back_idle", 32'(req_ready), 32'h1);
    chk("hold_no_valid", 32'(resp_valid), 32'h0);

    // Reset in the ACCESS cycle of a store must suppress the write.
    @(negedge clk);
    v = '{1'b1, 2'b00, 1'b0, 32'h40, 32'h55AA55AA, 1'b0, 32'h0, 32'h40};
    issue(v);
    @(negedge clk);
    chk("abort_dm_ena_pre", 32'(dm_ena), 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_dm_ena", 32'(dm_ena), 32'h0);
    chk("abort_dm_wr", 32'(dm_wr), 32'h0);
    chk("abort_dm_addr", dm_addr, 32'h0);
    chk("abort_dm_wdata32", dm_wdata32, 32'h0);
    chk("abort_req_ready", 32'(req_ready), 32'h1);
    chk("abort_resp_valid", 32'(resp_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_mem", {mem[12'h43], mem[12'h42], mem[12'h41], mem[12'h40]}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abort_no_resp%0d", k), 32'(resp_valid), 32'h0);
    end
    v = '{1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 32'h40};
    run_vec(100, v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
